// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: initiator side of the divider start/busy handshake.
// Stalls the CPU while a DIV/DIVU runs. Converts signed operands to
// magnitudes for the unsigned core, pulses start, waits for busy to drop,
// then sign-corrects the results and strobes HI (remainder) / LO (quotient).
// Optional build macro: DIV_ZERO_BYPASS_EN. When it is defined, a zero
// divisor skips the core and completes in one cycle with the same results.
module div_issue_ctrl (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        op_valid,
   input  logic        op_signed,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        stall,
   output logic        hilo_we,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        div_by_zero,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   output logic        div_start,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   input  logic        div_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_LAUNCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic load_op;    // capture operands and sign flags
   logic load_res;   // capture sign-corrected core results
   logic load_byp;   // capture divide-by-zero results without the core
   logic neg_q;
   logic neg_r;
   logic zero_flag;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state and handshake outputs; start is high only in START.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      hilo_we   = 1'b0;
      div_start = 1'b0;
      load_op   = 1'b0;
      load_res  = 1'b0;
      load_byp  = 1'b0;
      case (state)
         S_IDLE: begin
            if (op_valid) begin
               stall     = 1'b1;
               load_op   = 1'b1;
               state_nxt = S_START;
`ifdef DIV_ZERO_BYPASS_EN
               if (rt_val == '0) begin
                  load_byp  = 1'b1;
                  state_nxt = S_DONE;
               end
`endif
            end
         end
         S_START: begin
            stall     = 1'b1;
            div_start = 1'b1;
            state_nxt = S_LAUNCH;
         end
         S_LAUNCH: begin
            // Core launches on the edge where it sees start fall.
            stall     = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            stall = 1'b1;
            if (!div_busy) begin
               load_res  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // op_valid still belongs to the completing instruction here.
            hilo_we   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand magnitudes and sign-correction flags, captured at acceptance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_dividend <= '0;
         div_divisor  <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         zero_flag    <= 1'b0;
      end else if (load_op) begin
         div_dividend <= (op_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
         div_divisor  <= (op_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
         neg_q        <= op_signed & (rs_val[31] ^ rt_val[31]);
         neg_r        <= op_signed & rs_val[31];
         zero_flag    <= (rt_val == '0);
      end
   end

   // HI/LO results; held until the next completion.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hi_out      <= '0;
         lo_out      <= '0;
         div_by_zero <= 1'b0;
      end else if (load_res) begin
         lo_out      <= neg_q ? (~div_q + 32'd1) : div_q;
         hi_out      <= neg_r ? (~div_r + 32'd1) : div_r;
         div_by_zero <= zero_flag;
      end else if (load_byp) begin
         // Same values the core path yields for a zero divisor:
         // q = all ones, r = |rs|, then sign correction.
         hi_out      <= rs_val;
         lo_out      <= (op_signed && rs_val[31]) ? 32'd1 : '1;
         div_by_zero <= 1'b1;
      end
   end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl: behavioural 32-iteration divider core plus
// directed and random DIV/DIVU operations checked against an arithmetic
// reference for results, latency, stall and start timing.
module tb_div_issue_ctrl;

   logic        clock;
   logic        reset_n;
   logic        op_valid;
   logic        op_signed;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        stall;
   logic        hilo_we;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_by_zero;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_start;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_busy;

   int vectors;
   int miscompares;

`ifdef DIV_ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   div_issue_ctrl dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .op_valid     (op_valid),
      .op_signed    (op_signed),
      .rs_val       (rs_val),
      .rt_val       (rt_val),
      .stall        (stall),
      .hilo_we      (hilo_we),
      .hi_out       (hi_out),
      .lo_out       (lo_out),
      .div_by_zero  (div_by_zero),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_start    (div_start),
      .div_q        (div_q),
      .div_r        (div_r),
      .div_busy     (div_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Unsigned divider core model: launches when start falls, busy for 32 cycles.
   logic       core_start_d;
   logic [4:0] core_cnt;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         core_start_d <= 1'b0;
         div_busy     <= 1'b0;
         core_cnt     <= '0;
         div_q        <= '0;
         div_r        <= '0;
      end else begin
         core_start_d <= div_start;
         if (div_busy) begin
            if (core_cnt == 5'd0) div_busy <= 1'b0;
            else                  core_cnt <= core_cnt - 5'd1;
         end else if (core_start_d && !div_start) begin
            div_busy <= 1'b1;
            core_cnt <= 5'd31;
            if (div_divisor == 32'd0) begin
               div_q <= 32'hFFFF_FFFF;
               div_r <= div_dividend;
            end else begin
               div_q <= div_dividend / div_divisor;
               div_r <= div_dividend % div_divisor;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // MIPS DIV/DIVU reference, including the divisor-zero and overflow cases.
   function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
      int sa, sb;
      if (b == 32'd0) begin
         hi = a;
         lo = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
         end else begin
            sa = a;
            sb = b;
            lo = sa / sb;
            hi = sa % sb;
         end
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endfunction

   function automatic logic [31:0] mag(input bit s, input logic [31:0] x);
      return (s && x[31]) ? (32'd0 - x) : x;
   endfunction

   // Issue one op starting at the current cycle (called #1 after a rising edge)
   // and follow it to its write strobe. With keep=1 op_valid stays high for a
   // back-to-back follow-on op issued by the caller.
   task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b, input bit keep);
      logic [31:0] e_hi, e_lo;
      int lat;
      int cyc;
      bit done;
      ref_div(s, a, b, e_hi, e_lo);
      lat = (BYPASS && b == 32'd0) ? 1 : 36;
      op_valid  = 1'b1;
      op_signed = s;
      rs_val    = a;
      rt_val    = b;
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc <= 60) begin
         @(negedge clock);
         check("stall", {31'd0, stall}, {31'd0, cyc < lat});
         check("div_start", {31'd0, div_start}, {31'd0, lat == 36 && cyc == 1});
         if (lat == 36 && cyc == 1) begin
            check("dividend_mag", div_dividend, mag(s, a));
            check("divisor_mag", div_divisor, mag(s, b));
         end
         if (cyc == lat) begin
            check("hilo_we", {31'd0, hilo_we}, 32'd1);
            check("hi_out", hi_out, e_hi);
            check("lo_out", lo_out, e_lo);
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, b == 32'd0});
            done = 1'b1;
         end else begin
            check("hilo_we_idle", {31'd0, hilo_we}, 32'd0);
         end
         @(posedge clock);
         #1;
         cyc++;
      end
      if (!done) check("strobe_timeout", 32'd0, 32'd1);
      if (!keep) begin
         op_valid = 1'b0;
         @(negedge clock);
         check("hold_hi", hi_out, e_hi);
         check("hold_lo", lo_out, e_lo);
         check("hold_stall", {31'd0, stall}, 32'd0);
         check("hold_we", {31'd0, hilo_we}, 32'd0);
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_we"}, {31'd0, hilo_we}, 32'd0);
      check({tag, "_start"}, {31'd0, div_start}, 32'd0);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
      check({tag, "_hi"}, hi_out, 32'd0);
      check({tag, "_lo"}, lo_out, 32'd0);
      check({tag, "_dvd"}, div_dividend, 32'd0);
      check({tag, "_dvs"}, div_divisor, 32'd0);
   endtask

   initial begin
      bit          s;
      logic [31:0] a, b;
      int          sel;
      vectors     = 0;
      miscompares = 0;
      reset_n   = 1'b0;
      op_valid  = 1'b0;
      op_signed = 1'b0;
      rs_val    = '0;
      rt_val    = '0;
      #12;
      check_all_zero("rst");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Directed cases
      do_op(1'b0, 32'd100, 32'd7, 1'b0);
      do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      do_op(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
      do_op(1'b0, 32'd12345, 32'd0, 1'b0);
      do_op(1'b1, 32'd77, 32'hFFFF_FFF6, 1'b0);

      // Reset in cycle 20 of a DIVU
      op_valid  = 1'b1;
      op_signed = 1'b0;
      rs_val    = 32'd1000;
      rt_val    = 32'd7;
      repeat (20) @(posedge clock);
      #2;
      reset_n  = 1'b0;
      op_valid = 1'b0;
      #1;
      check_all_zero("midrst");
      check("midrst_busy", {31'd0, div_busy}, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      do_op(1'b0, 32'd9, 32'd3, 1'b0);

      // Back-to-back: op_valid held through DONE into the next op
      do_op(1'b0, 32'd10, 32'd3, 1'b1);
      do_op(1'b0, 32'd20, 32'd6, 1'b0);

      // Random operations
      for (int i = 0; i < 24; i++) begin
         s   = 1'($urandom % 2);
         a   = $urandom;
         sel = int'($urandom % 5);
         case (sel)
            0:       b = 32'd0;
            1:       b = $urandom % 16;
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if ($urandom % 4 == 0) a = $urandom % 1000;
         do_op(s, a, b, (i % 3 == 0) && (i != 23));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Initiator side of the divider's start/busy handshake. Accepts DIV/DIVU requests from the single-cycle CPU datapath, stalls the PC, converts signed operands to magnitudes, sequences the start pulse into the unsigned divider core, waits out its 32 iterations, applies sign correction and writes HI (remainder) / LO (quotient). Sits between the decode/execute stage and the unsigned divider core.

## Interface

Parameters:
- none (fixed 32-bit datapath)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset; the top connects `~reset_n` to the divider core's active-high reset
- `op_valid`  in  1  current instruction is DIV/DIVU; held stable while `stall`=1
- `op_signed`  in  1  1 = DIV (two's complement), 0 = DIVU
- `rs_val`  in  32  dividend
- `rt_val`  in  32  divisor
- `stall`  out  1  freeze PC/instruction
- `hilo_we`  out  1  one-cycle write strobe for HI/LO
- `hi_out`  out  32  remainder
- `lo_out`  out  32  quotient
- `div_by_zero`  out  1  divisor was 0; valid with `hilo_we`
- `div_dividend`  out  32  magnitude dividend to core
- `div_divisor`  out  32  magnitude divisor to core
- `div_start`  out  1  start to core
- `div_q`  in  32  core quotient
- `div_r`  in  32  core remainder
- `div_busy`  in  1  core busy

## Operation

- States: IDLE, START, LAUNCH, WAIT, DONE.
- IDLE: on `op_valid`=1, register magnitudes (`|rs|`, `|rt|` if `op_signed`, else raw), `neg_q` = signed & (rs[31]^rt[31]), `neg_r` = signed & rs[31], zero flag = (`rt_val`==0). Go to START.
- START: `div_start`=1. Go to LAUNCH.
- LAUNCH: `div_start`=0. The core launches on the edge at which it sees start fall. Go to WAIT.
- WAIT: `div_start`=0. Stay while `div_busy`=1. When `div_busy`=0, register `lo_out` = neg_q ? −div_q : div_q and `hi_out` = neg_r ? −div_r : div_r (32-bit two's complement, wrap). Go to DONE.
- DONE: `hilo_we`=1 for exactly this cycle. `op_valid` is ignored because it still belongs to the completing instruction. Go to IDLE.
- `stall` = (IDLE & op_valid) | START | LAUNCH | WAIT. `stall` is 0 in DONE.
- `div_start` stays low in every state except START. The core must never see a second falling edge while busy.
- INT_MIN / −1: magnitudes 0x80000000 / 1. Result is LO=0x80000000, HI=0 (wraps, no trap).
- Divisor 0, core path: core returns q=0xFFFFFFFF, r=dividend magnitude. After fixup, HI=`rs_val`. LO=0x00000001 if signed and rs negative, else 0xFFFFFFFF.
- `hi_out`, `lo_out` and `div_by_zero` hold their values until the next DONE.

## Timing

- Reset (async, any state, including mid-divide): state=IDLE. `stall`, `hilo_we`, `div_start`, `div_by_zero` = 0. `hi_out`, `lo_out`, `div_dividend`, `div_divisor` = 0. The core is reset simultaneously.
- Cycle 0: IDLE, `op_valid` high, `stall` high combinationally.
- Cycle 1: START. Cycle 2: LAUNCH; `div_busy` rises at the end of cycle 2.
- Cycles 3–34: WAIT with `div_busy`=1. `div_busy`=0 first seen in cycle 35.
- Cycle 36: DONE with `hilo_we`=1 and `stall`=0.
- Total latency is 36 cycles from acceptance to write strobe. The next op can be accepted in cycle 37 at the earliest.

## Configuration

- `DIV_ZERO_BYPASS_EN` defined: in IDLE with `rt_val`==0, skip START/LAUNCH/WAIT. Register HI/LO directly with the divisor-zero values above and go to DONE. Latency is 1 cycle (`hilo_we` in cycle 1). The core is never started.
- Undefined: divide by zero runs through the core with the normal 36-cycle latency.
- Both builds produce identical `hi_out`/`lo_out`/`div_by_zero` values.

## Test plan

- DIVU 100/7 -> `hilo_we` in cycle 36; LO=14, HI=2; `stall` high in cycles 0–35; `div_start` high only in cycle 1.
- DIV −100/7 -> LO=0xFFFFFFF2 (−14), HI=0xFFFFFFFE (−2).
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV −5/0 -> HI=0xFFFFFFFB, LO=1, `div_by_zero`=1. Strobe in cycle 1 with `DIV_ZERO_BYPASS_EN` defined, cycle 36 without.
- Assert `reset_n`=0 in cycle 20 of a DIVU -> all outputs 0 immediately. After release, a fresh 9/3 gives LO=3, HI=0 at cycle 36.
- Two back-to-back DIVU ops (10/3 then 20/6) -> each takes 36 cycles; `op_valid` during DONE is not re-accepted; results LO=3/HI=1, then LO=3/HI=2.
